// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl_if
// Description : Button/status bundle between the stopwatch control stage and
//               its environment (buttons, counter chain, display stage).
// Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_ctrl_if;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic       dir_down;
  logic       at_zero;
  logic       tick;
  logic       ctrl;
  logic       set;
  logic       running;
  logic       lap_hold;
  logic       expired;
  logic [1:0] state;

  // Environment side: drives buttons and counter status, observes controls
  modport master (
    output btn_start_stop, btn_clear, btn_lap, dir_down, at_zero,
    input  tick, ctrl, set, running, lap_hold, expired, state
  );

  // Control stage side
  modport slave (
    input  btn_start_stop, btn_clear, btn_lap, dir_down, at_zero,
    output tick, ctrl, set, running, lap_hold, expired, state
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch front-end. Synchronizes and debounces the three
//               buttons, runs the IDLE/RUN/PAUSE/DONE state machine and
//               produces the prescaled tick, direction and load controls for
//               the digit counter chain.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int CLK_DIV    = 100000,
  parameter int DEB_CYCLES = 16
) (
  input wire              clk,
  input wire              reset,
  stopwatch_ctrl_if.slave bus
);

  localparam int c_DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int c_PW = $clog2(CLK_DIV);
  localparam logic [c_DW-1:0] c_DEB_LAST = c_DW'(DEB_CYCLES - 1);
  localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(CLK_DIV - 1);
  localparam int c_B_SS  = 0;
  localparam int c_B_CLR = 1;
  localparam int c_B_LAP = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  logic [2:0]      w_btn_raw;
  logic [2:0]      w_press;
  logic            w_clr;
  logic            w_ss;
  logic            w_lap;
  logic            w_wrap;
  logic            w_terminal;

  state_t          r_state;
  logic [c_PW-1:0] r_pre;
  logic            r_tick;
  logic            r_set;
  logic            r_ctrl;
  logic            r_lap_hold;
  logic            r_expired;
  logic            r_running;

  assign w_btn_raw = {bus.btn_lap, bus.btn_clear, bus.btn_start_stop};

  // One independent synchronize/debounce/edge-detect path per button
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic            r_sync1;
    logic            r_sync2;
    logic            r_deb;
    logic            r_deb_d;
    logic            r_press;
    logic [c_DW-1:0] r_cnt;

    // Level is accepted only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_deb   <= 1'b0;
        r_deb_d <= 1'b0;
        r_press <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_btn_raw[gi];
        r_sync2 <= r_sync1;
        if (r_sync2 != r_deb) begin
          if (r_cnt == c_DEB_LAST) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
        r_deb_d <= r_deb;
        r_press <= r_deb & ~r_deb_d;
      end
    end

    assign w_press[gi] = r_press;
  end

  // Coincident presses: clear beats start/stop, which beats lap
  assign w_clr = w_press[c_B_CLR];
  assign w_ss  = w_press[c_B_SS] & ~w_press[c_B_CLR];
  assign w_lap = w_press[c_B_LAP] & ~w_press[c_B_CLR] & ~w_press[c_B_SS];

  // A down-count wrap while the chain already reads zero would underflow it
  assign w_wrap     = (r_pre == c_PRE_LAST);
  assign w_terminal = w_wrap & r_ctrl & bus.at_zero;

  // Control state machine with prescaler and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pre      <= '0;
      r_tick     <= 1'b0;
      r_set      <= 1'b0;
      r_ctrl     <= 1'b0;
      r_lap_hold <= 1'b0;
      r_expired  <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_set  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ctrl <= bus.dir_down;
          r_pre  <= '0;
          if (w_clr) begin
            r_set <= 1'b1;
          end else if (w_ss) begin
            if (r_ctrl && bus.at_zero) begin
              r_state   <= S_DONE;
              r_expired <= 1'b1;
            end else begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_clr) begin
            r_state    <= S_IDLE;
            r_set      <= 1'b1;
            r_lap_hold <= 1'b0;
            r_pre      <= '0;
            r_running  <= 1'b0;
          end else if (w_terminal) begin
            r_state   <= S_DONE;
            r_pre     <= '0;
            r_running <= 1'b0;
            r_expired <= 1'b1;
          end else begin
            // The cycle that sees a pause press still counts
            if (w_wrap) begin
              r_pre  <= '0;
              r_tick <= 1'b1;
            end else begin
              r_pre <= r_pre + 1'b1;
            end
            if (w_ss) begin
              r_state   <= S_PAUSE;
              r_running <= 1'b0;
            end else if (w_lap) begin
              r_lap_hold <= ~r_lap_hold;
            end
          end
        end
        S_PAUSE: begin
          if (w_clr) begin
            r_state    <= S_IDLE;
            r_set      <= 1'b1;
            r_lap_hold <= 1'b0;
            r_pre      <= '0;
          end else if (w_ss) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end else if (w_lap) begin
            r_lap_hold <= ~r_lap_hold;
          end
        end
        S_DONE: begin
          if (w_clr) begin
            r_state    <= S_IDLE;
            r_set      <= 1'b1;
            r_lap_hold <= 1'b0;
            r_pre      <= '0;
            r_expired  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tick     = r_tick;
  assign bus.ctrl     = r_ctrl;
  assign bus.set      = r_set;
  assign bus.running  = r_running;
  assign bus.lap_hold = r_lap_hold;
  assign bus.expired  = r_expired;
  assign bus.state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Directed self-checking bench for stopwatch_ctrl with a state
//               transition scoreboard (CLK_DIV=4, DEB_CYCLES=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;
  localparam int CLK_DIV    = 4;
  localparam int DEB_CYCLES = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks   = 0;
  int failures = 0;
  int tick_cnt = 0;
  int set_cnt  = 0;

  typedef struct {
    logic [1:0] st;
    string      tag;
  } exp_t;
  exp_t       exp_q[$];
  logic [1:0] mon_prev = 2'b00;

  stopwatch_ctrl_if u_if ();

  stopwatch_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .DEB_CYCLES(DEB_CYCLES)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] st, input string tag);
    exp_t e;
    e.st  = st;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Step n falling edges, then settle 1 ns so monitor updates are visible
  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    do begin
      nclk(1);
      n++;
    end while (!u_if.tick && n < 20);
    chk(tag, 32'(u_if.tick), 32'd1);
  endtask

  // Scoreboard: every observed state change must match the next expectation
  always @(negedge clk) begin
    exp_t e;
    if (u_if.tick) tick_cnt++;
    if (u_if.set) set_cnt++;
    if (u_if.tick | u_if.set) chk("tick_set_exclusive", 32'(u_if.tick & u_if.set), 32'd0);
    if (u_if.state !== mon_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transition", 32'(u_if.state), 32'(mon_prev));
      end else begin
        e = exp_q.pop_front();
        chk(e.tag, 32'(u_if.state), 32'(e.st));
      end
      mon_prev = u_if.state;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int s0;
    u_if.btn_start_stop = 1'b0;
    u_if.btn_clear      = 1'b0;
    u_if.btn_lap        = 1'b0;
    u_if.dir_down       = 1'b1;
    u_if.at_zero        = 1'b0;

    // 1: reset values, idle without ticks, ctrl tracking dir_down
    #1 reset = 1'b0;
    nclk(3);
    chk("reset_outputs", 32'({u_if.tick, u_if.set, u_if.ctrl, u_if.lap_hold,
                              u_if.expired, u_if.running, u_if.state}), 32'd0);
    u_if.dir_down = 1'b0;
    reset = 1'b1;
    t0 = tick_cnt;
    nclk(50);
    chk("idle_no_tick", 32'(tick_cnt - t0), 32'd0);
    chk("idle_state", 32'(u_if.state), 32'd0);
    u_if.dir_down = 1'b1;
    nclk(1);
    chk("ctrl_follow_1", 32'(u_if.ctrl), 32'd1);
    u_if.dir_down = 1'b0;
    nclk(1);
    chk("ctrl_follow_0", 32'(u_if.ctrl), 32'd0);

    // 2: start latency 2+3+1+1, tick every 4 cycles, glitch rejected
    push_exp(2'b01, "start_run");
    u_if.btn_start_stop = 1'b1;
    nclk(6);
    chk("start_lat_early", 32'(u_if.state), 32'd0);
    nclk(1);
    chk("start_lat", 32'({u_if.running, u_if.state}), 32'b101);
    for (int k = 1; k <= 8; k++) begin
      nclk(1);
      chk("tick_period", 32'(u_if.tick), 32'((k % 4) == 0));
      if (k == 3) u_if.btn_start_stop = 1'b0;
    end
    u_if.btn_start_stop = 1'b1;
    nclk(2);
    u_if.btn_start_stop = 1'b0;
    nclk(15);
    chk("glitch_ignored", 32'(u_if.state), 32'd1);

    // 3: pause mid-period, no ticks while paused, resume continues period
    wait_tick("t3_sync");
    push_exp(2'b10, "pause");
    u_if.btn_start_stop = 1'b1;
    nclk(7);
    chk("pause_state", 32'(u_if.state), 32'd2);
    nclk(3);
    u_if.btn_start_stop = 1'b0;
    t0 = tick_cnt;
    nclk(20);
    chk("pause_no_tick", 32'(tick_cnt - t0), 32'd0);
    push_exp(2'b01, "resume");
    u_if.btn_start_stop = 1'b1;
    nclk(7);
    chk("resume_state", 32'({u_if.tick, u_if.state}), 32'b001);
    nclk(1);
    chk("resume_first_tick", 32'(u_if.tick), 32'd1);
    nclk(2);
    u_if.btn_start_stop = 1'b0;
    nclk(10);

    // 4: lap toggles with ticks uninterrupted; clear from PAUSE
    t0 = tick_cnt;
    u_if.btn_lap = 1'b1;
    nclk(7);
    chk("lap_on", 32'(u_if.lap_hold), 32'd1);
    nclk(3);
    u_if.btn_lap = 1'b0;
    nclk(10);
    u_if.btn_lap = 1'b1;
    nclk(7);
    chk("lap_off", 32'(u_if.lap_hold), 32'd0);
    nclk(3);
    u_if.btn_lap = 1'b0;
    nclk(10);
    chk("lap_ticks", 32'(tick_cnt - t0), 32'd10);
    push_exp(2'b10, "pause2");
    u_if.btn_start_stop = 1'b1;
    nclk(10);
    u_if.btn_start_stop = 1'b0;
    nclk(10);
    u_if.btn_lap = 1'b1;
    nclk(7);
    chk("lap_in_pause", 32'(u_if.lap_hold), 32'd1);
    nclk(3);
    u_if.btn_lap = 1'b0;
    nclk(10);
    push_exp(2'b00, "clear_from_pause");
    s0 = set_cnt;
    u_if.btn_clear = 1'b1;
    nclk(6);
    chk("clear_set_early", 32'(u_if.set), 32'd0);
    nclk(1);
    chk("clear_pause_out", 32'({u_if.set, u_if.lap_hold, u_if.running, u_if.state}), 32'b10000);
    nclk(3);
    u_if.btn_clear = 1'b0;
    nclk(10);
    chk("clear_single_set", 32'(set_cnt - s0), 32'd1);

    // 5: count down to DONE at the wrap with at_zero; DONE ignores start
    u_if.dir_down = 1'b1;
    nclk(2);
    chk("ctrl_down", 32'(u_if.ctrl), 32'd1);
    push_exp(2'b01, "start_down");
    u_if.btn_start_stop = 1'b1;
    nclk(7);
    chk("run_down", 32'({u_if.ctrl, u_if.state}), 32'b101);
    nclk(3);
    chk("presc_cleared_early", 32'(u_if.tick), 32'd0);
    u_if.btn_start_stop = 1'b0;
    nclk(1);
    chk("presc_cleared_tick", 32'(u_if.tick), 32'd1);
    u_if.dir_down = 1'b0;
    nclk(2);
    chk("ctrl_frozen", 32'(u_if.ctrl), 32'd1);
    u_if.at_zero = 1'b1;
    push_exp(2'b11, "done");
    nclk(2);
    chk("done_at_wrap", 32'({u_if.tick, u_if.expired, u_if.running, u_if.state}), 32'b01011);
    u_if.btn_start_stop = 1'b1;
    nclk(10);
    u_if.btn_start_stop = 1'b0;
    nclk(10);
    chk("done_start_ignored", 32'({u_if.expired, u_if.state}), 32'b111);
    push_exp(2'b00, "clear_from_done");
    u_if.btn_clear = 1'b1;
    nclk(7);
    chk("clear_done_out", 32'({u_if.set, u_if.expired, u_if.state}), 32'b1000);
    nclk(3);
    u_if.btn_clear = 1'b0;
    u_if.at_zero = 1'b0;
    nclk(10);
    chk("ctrl_refollow", 32'(u_if.ctrl), 32'd0);

    // 6: clear beats start/stop; asynchronous reset in RUN cancels tick
    push_exp(2'b01, "start6");
    u_if.btn_start_stop = 1'b1;
    nclk(10);
    u_if.btn_start_stop = 1'b0;
    nclk(10);
    push_exp(2'b00, "clear_wins");
    u_if.btn_start_stop = 1'b1;
    u_if.btn_clear      = 1'b1;
    nclk(7);
    chk("clear_wins_out", 32'({u_if.set, u_if.state}), 32'b100);
    nclk(3);
    u_if.btn_start_stop = 1'b0;
    u_if.btn_clear      = 1'b0;
    nclk(10);
    push_exp(2'b01, "start7");
    u_if.btn_start_stop = 1'b1;
    nclk(10);
    u_if.btn_start_stop = 1'b0;
    nclk(10);
    wait_tick("t6_sync");
    nclk(3);
    chk("pre_reset_run", 32'({u_if.tick, u_if.state}), 32'b001);
    push_exp(2'b00, "async_reset");
    t0 = tick_cnt;
    #2 reset = 1'b0;
    #1;
    chk("async_reset_out", 32'({u_if.tick, u_if.set, u_if.ctrl, u_if.lap_hold,
                                u_if.expired, u_if.running, u_if.state}), 32'd0);
    nclk(1);
    chk("reset_no_tick", 32'({u_if.tick, u_if.state}), 32'd0);
    reset = 1'b1;
    nclk(10);
    chk("after_reset", 32'({u_if.state, 8'(tick_cnt - t0)}), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
